mux_arb_2to1: RTL
=================

MUX_ARB_2TO1 -- requirements
Module: mux_arb_2to1

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, data width of each input channel and of the output channel.
REQ-002 SHALL have ports: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: in0_valid  input  1  source 0 beat available.
REQ-005 SHALL have ports: in0_data  input  WIDTH  source 0 payload.
REQ-006 SHALL have ports: in0_last  input  1  source 0 final beat of packet; used only under ARB_LOCK_EN.
REQ-007 SHALL have ports: in0_ready  output  1  source 0 beat accepted this cycle when in0_valid is also high.
REQ-008 SHALL have ports: in1_valid, in1_data, in1_last, in1_ready, with the same widths and meanings for source 1.
REQ-009 SHALL have ports: out_valid  output  1  output register holds a beat.
REQ-010 SHALL have ports: out_data  output  WIDTH  registered payload.
REQ-011 SHALL have ports: out_src  output  1  index of the source of the current output beat.
REQ-012 SHALL have ports: out_ready  input  1  downstream accepts the output beat.
REQ-013 SHALL have ports: sel  output  1  current grant index driving the 2:1 data mux.

Function
REQ-014 SHALL define accept_ok = !out_valid | out_ready; a 1-entry output register may load only when accept_ok is high.
REQ-015 SHALL assert inX_ready = accept_ok & (sel == X) & grant_valid, combinationally.
REQ-016 SHALL use round-robin arbitration: if both inputs are valid, grant the input not granted last; if only one is valid, grant it with no bubble; if none is valid, hold sel.
REQ-017 SHALL, on a beat transfer from input X, load out_data = inX_data, out_src = X and out_valid = 1 on the next edge; input-to-output latency is 1 cycle.
REQ-018 SHALL clear out_valid after an out_valid & out_ready handshake with no new transfer in the same cycle; a simultaneous drain and load SHALL replace the beat with no gap.
REQ-019 SHALL keep out_data and out_src stable while out_valid = 1 and out_ready = 0.
REQ-020 SHALL sustain 1 beat/cycle when out_ready is held high.
REQ-021 SHALL update the round-robin pointer (last_grant) only on an accepted input beat.

Reset
REQ-022 SHALL, while rst_n = 0, asynchronously force out_valid = 0, out_data = 0, out_src = 0, sel = 0, last_grant = 1 (input 0 has first priority), and FSM = IDLE.
REQ-023 SHALL, on reset asserted mid-packet or with a beat pending, discard the pending beat and any lock; there is no recovery of lost data.

Configuration
REQ-024 SHALL provide macro MUX_ARB_LOCK_EN; when undefined, arbitrate per beat, ignore inX_last, and hold the FSM permanently in IDLE.
REQ-025 SHALL, with MUX_ARB_LOCK_EN defined, implement FSM states IDLE, OWN0 and OWN1 as follows:
- IDLE: accepting a beat from X with inX_last = 0 moves to OWNX.
- OWNX: grants only X, with sel fixed at X, even if the other input is valid.
- OWNX: accepting a beat from X with inX_last = 1 moves to IDLE.
- A single-beat packet (last = 1 on the first beat) stays in IDLE.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE = 0, OWN0 = 1, OWN1 = 2) and the WIDTH default constant in shared package mux_ctrl_pkg.
REQ-027 SHALL implement the pointer-based grant decision as combinational sub-module rr_pick2 (inputs: valid[1:0], last_grant; outputs: grant_valid, grant_idx).

Verification
REQ-028 SHALL cover: with out_ready = 1, in0_valid = in1_valid = 1 for 6 cycles, data 0xA0/0xB0 -> out_src = 0,1,0,1,0,1 starting one cycle after reset release.
REQ-029 SHALL cover: only in1_valid = 1 with data 0x5C -> in1_ready = 1 in the same cycle, then out_data = 0x5C and out_src = 1 on the next cycle.
REQ-030 SHALL cover: out_ready = 0 for 4 cycles with out_valid = 1 and out_data = 0x33 -> out_data stays 0x33, both inX_ready = 0, and no beat is lost after out_ready returns to 1.
REQ-031 SHALL cover: with MUX_ARB_LOCK_EN, a 3-beat packet on in0 (last on beat 3) with in1_valid held high -> out_src = 0,0,0 then 1.
REQ-032 SHALL cover: rst_n driven low for 1 cycle during OWN1 with out_valid = 1 -> out_valid = 0 immediately, and the first post-reset grant goes to in0 when both inputs are valid.

Source files
------------

// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the 2:1 arbitrating mux: FSM state encoding and the
// default channel width.
package mux_ctrl_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick: prefers the requester not granted last when
// both are valid, otherwise grants whichever one is valid.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Pointer-based grant decision
    always_comb begin
        grant_valid = |valid;
        grant_idx   = ~last_grant;
        if (valid == 2'b01) begin
            grant_idx = 1'b0;
        end else if (valid == 2'b10) begin
            grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/mux_arb_2to1.sv
// Round-robin 2:1 arbitrating mux with a 1-entry registered output stage.
// Optional packet lock (hold the grant until inX_last) is enabled by defining
// MUX_ARB_LOCK_EN; without it arbitration is per beat and inX_last is ignored.
module mux_arb_2to1
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_grant;
    logic       sel_q;
    logic       rr_valid;
    logic       rr_idx;
    logic       grant_valid;
    logic       grant_idx;
    logic       accept_ok;
    logic       fire;

    rr_pick2 u_pick (
        .valid       ({in1_valid, in0_valid}),
        .last_grant  (last_grant),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    // Grant selection: round-robin pick, overridden by an owning packet
    always_comb begin
        grant_valid = rr_valid;
        grant_idx   = rr_idx;
        case (state_q)
            OWN0: begin
                grant_valid = in0_valid;
                grant_idx   = 1'b0;
            end
            OWN1: begin
                grant_valid = in1_valid;
                grant_idx   = 1'b1;
            end
            default: ;
        endcase
        // No acceptance while reset is held, and sel reads 0 throughout reset
        if (!rst_n) begin
            grant_valid = 1'b0;
        end
    end

    assign sel       = rst_n & (grant_valid ? grant_idx : sel_q);
    assign accept_ok = ~out_valid | out_ready;
    assign fire      = accept_ok & grant_valid;
    assign in0_ready = fire & ~sel;
    assign in1_ready = fire & sel;

    // Grant bookkeeping: hold sel while idle, advance pointer on accepted beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (grant_valid) begin
                sel_q <= grant_idx;
            end
            if (fire) begin
                last_grant <= sel;
            end
        end
    end

    // Output register: load on transfer, clear on drain without reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= sel ? in1_data : in0_data;
            out_src   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MUX_ARB_LOCK_EN
    logic mux_last;
    assign mux_last = sel ? in1_last : in0_last;

    // Packet lock next-state: a non-last first beat takes ownership, last beat releases
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fire && !mux_last) begin
                    state_d = sel ? OWN1 : OWN0;
                end
            end
            OWN0, OWN1: begin
                if (fire && mux_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    logic unused_last;
    assign unused_last = in0_last ^ in1_last;

    // Per-beat arbitration: FSM never leaves IDLE
    always_comb begin
        state_d = IDLE;
    end
`endif

endmodule
